// File: rtl/transmit.sv
// Serial frame transmitter: start bit, 4-bit size, N data bytes, CRC-8 (0x07), stop bit,
// with 5-identical-bit stuffing across the size/data/CRC fields.
module transmit (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   baudrate,
    input  logic         start,
    input  logic [3:0]   size,
    input  logic [127:0] framedata,
    output logic         TX,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BaudW = 8;
    localparam int unsigned ByteW = 4;
    localparam int unsigned BitW  = 3;
    localparam int unsigned RunW  = 3;
    localparam int unsigned CrcW  = 8;

    typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} state_t;

    state_t             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [BaudW-1:0]   cnt_q, cnt_d;
    logic [3:0]         size_q, size_d;
    logic [127:0]       data_q, data_d;
    logic [ByteW-1:0]   byte_q, byte_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [RunW-1:0]    run_q, run_d;
    logic               last_q, last_d;
    logic               stuff_q, stuff_d;
    logic [CrcW-1:0]    crc_q, crc_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    state_t             adv_state;
    logic [ByteW-1:0]   adv_byte;
    logic [BitW-1:0]    adv_bit;
    logic               adv_val;
    logic               bit_end;
    logic               in_field;
    logic [RunW-1:0]    run_nxt;

    function automatic logic [CrcW-1:0] crc_step(input logic [CrcW-1:0] c, input logic b);
        return {c[CrcW-2:0], 1'b0} ^ ((c[CrcW-1] ^ b) ? 8'h07 : 8'h00);
    endfunction

    assign bit_end  = (cnt_q == baud_q - 8'd1);
    assign in_field = (state_q == SIZE) || (state_q == DATA) || (state_q == CRC);
    assign run_nxt  = ((run_q != 3'd0) && (tx_q == last_q)) ? run_q + 3'd1 : 3'd1;

    // Next field position after the current one, and the bit value found there.
    always_comb begin
        adv_state = state_q;
        adv_byte  = byte_q;
        adv_bit   = bit_q + 3'd1;
        case (state_q)
            START: begin
                adv_state = SIZE;
                adv_bit   = 3'd0;
                adv_byte  = 4'd0;
            end
            SIZE: if (bit_q == 3'd3) begin
                adv_bit   = 3'd0;
                adv_state = (size_q == 4'd0) ? CRC : DATA;
            end
            DATA: if (bit_q == 3'd7) begin
                adv_bit = 3'd0;
                if (byte_q == size_q - 4'd1) adv_state = CRC;
                else                         adv_byte  = byte_q + 4'd1;
            end
            CRC: if (bit_q == 3'd7) begin
                adv_bit   = 3'd0;
                adv_state = STOP;
            end
            default: ;
        endcase
        case (adv_state)
            SIZE:    adv_val = size_q[~adv_bit[1:0]];
            DATA:    adv_val = data_q[{adv_byte, ~adv_bit}];
            CRC:     adv_val = crc_q[~adv_bit];
            START:   adv_val = 1'b1;
            default: adv_val = 1'b0;
        endcase
    end

    // Frame sequencing: bit timing, stuffing decision, CRC accumulation as bits are launched.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        data_d  = data_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        run_d   = run_q;
        last_d  = last_q;
        stuff_d = stuff_q;
        crc_d   = crc_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = START;
                baud_d  = (baudrate == 8'd0) ? 8'd1 : baudrate;
                size_d  = size;
                data_d  = framedata;
                cnt_d   = 8'd0;
                byte_d  = 4'd0;
                bit_d   = 3'd0;
                run_d   = 3'd0;
                last_d  = 1'b0;
                stuff_d = 1'b0;
                crc_d   = 8'h00;
                tx_d    = 1'b1;
            end
            default: if (!bit_end) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd0;
                if (state_q == STOP) begin
                    state_d = IDLE;
                    tx_d    = 1'b0;
                end else if (in_field && !stuff_q && (run_nxt == 3'd5)) begin
                    // Stuff bit opens a new run of length one; position is held.
                    stuff_d = 1'b1;
                    tx_d    = ~tx_q;
                    run_d   = 3'd1;
                    last_d  = ~tx_q;
                end else begin
                    if (in_field && !stuff_q) begin
                        run_d  = run_nxt;
                        last_d = tx_q;
                    end
                    stuff_d = 1'b0;
                    state_d = adv_state;
                    byte_d  = adv_byte;
                    bit_d   = adv_bit;
                    tx_d    = adv_val;
                    if ((adv_state == SIZE) || (adv_state == DATA)) crc_d = crc_step(crc_q, adv_val);
                end
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == baud_q - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= 8'd1;
            cnt_q   <= 8'd0;
            size_q  <= 4'd0;
            data_q  <= 128'd0;
            byte_q  <= 4'd0;
            bit_q   <= 3'd0;
            run_q   <= 3'd0;
            last_q  <= 1'b0;
            stuff_q <= 1'b0;
            crc_q   <= 8'h00;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            data_q  <= data_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            run_q   <= run_d;
            last_q  <= last_d;
            stuff_q <= stuff_d;
            crc_q   <= crc_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TX   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit: fixed hand-derived frames plus a serial reference for long frames.
module tb_transmit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   baudrate;
    logic [3:0]   size;
    logic [127:0] framedata;
    logic         TX;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    transmit dut (
        .clk(clk), .reset(reset), .baudrate(baudrate), .start(start),
        .size(size), .framedata(framedata), .TX(TX), .busy(busy), .done(done)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_vec(input logic [31:0] v, input int n);
        exp_q.delete();
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // Reference line stream: CRC over size+data, stuffing over size+data+CRC.
    task automatic build_exp(input logic [3:0] s, input logic [127:0] d);
        bit f[$];
        logic [7:0] c;
        int run;
        bit last;
        for (int i = 3; i >= 0; i--) f.push_back(s[i]);
        for (int k = 0; k < int'(s); k++)
            for (int i = 7; i >= 0; i--) f.push_back(d[8*k+i]);
        c = 8'h00;
        foreach (f[j]) c = {c[6:0], 1'b0} ^ ((c[7] ^ f[j]) ? 8'h07 : 8'h00);
        for (int i = 7; i >= 0; i--) f.push_back(c[i]);
        exp_q.delete();
        exp_q.push_back(1'b1);
        run  = 0;
        last = 1'b0;
        foreach (f[j]) begin
            exp_q.push_back(f[j]);
            if (run > 0 && f[j] == last) run++;
            else run = 1;
            last = f[j];
            if (run == 5) begin
                exp_q.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        exp_q.push_back(1'b0);
    endtask

    task automatic launch(input logic [7:0] b, input logic [3:0] s, input logic [127:0] d);
        @(negedge clk);
        baudrate  = b;
        size      = s;
        framedata = d;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples every cycle from the one after accept until done; returns at the done cycle.
    task automatic capture(input string tag, input int baud_eff, input bit noisy);
        int ncyc;
        int nerr;
        bit fin;
        ncyc = 0;
        nerr = 0;
        fin  = 1'b0;
        while (!fin && ncyc < 5000) begin
            @(negedge clk);
            if ((ncyc / baud_eff) < exp_q.size()) begin
                if (TX !== exp_q[ncyc / baud_eff]) nerr++;
            end else begin
                nerr++;
            end
            if (busy !== 1'b1) nerr++;
            if (noisy) begin
                start     = 1'b1;
                baudrate  = 8'($urandom);
                size      = 4'($urandom);
                framedata = {$urandom, $urandom, $urandom, $urandom};
            end
            ncyc++;
            if (done === 1'b1) fin = 1'b1;
        end
        check({tag, " bit_errors"}, 32'(nerr), 32'd0);
        check({tag, " cycles"}, 32'(ncyc), 32'(exp_q.size() * baud_eff));
    endtask

    task automatic post(input string tag, input int d0);
        @(negedge clk);
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, " tx_after"}, {31'd0, TX}, 32'd0);
        check({tag, " done_after"}, {31'd0, done}, 32'd0);
        check({tag, " done_pulses"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    logic [127:0] d;
    logic [127:0] d2;
    int d0;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        baudrate  = 8'd1;
        size      = 4'd0;
        framedata = 128'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx", {31'd0, TX}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio busy", {31'd0, busy}, 32'd0);
        check("rst_prio tx", {31'd0, TX}, 32'd0);
        @(negedge clk);
        check("rst_prio still_idle", {31'd0, busy}, 32'd0);

        // Empty frame, one clock per bit
        d0 = done_cnt;
        launch(8'd1, 4'd0, 128'd0);
        load_vec(32'b1000001000001000, 16);
        capture("n0_b1", 1, 1'b0);
        post("n0_b1", d0);

        // Empty frame, four clocks per bit, payload ignored
        d0 = done_cnt;
        launch(8'd4, 4'd0, {4{32'hDEADBEEF}});
        load_vec(32'b1000001000001000, 16);
        capture("n0_b4", 4, 1'b0);
        post("n0_b4", d0);

        // Baudrate zero behaves as one
        d0 = done_cnt;
        launch(8'd0, 4'd0, 128'd0);
        load_vec(32'b1000001000001000, 16);
        capture("n0_b0", 1, 1'b0);
        post("n0_b0", d0);

        // One 0xFF byte: stuff in data and in CRC (CRC = 0xE6)
        d0 = done_cnt;
        launch(8'd1, 4'd1, 128'hFF);
        load_vec(32'b100011111011111011001100, 24);
        capture("n1_ff", 1, 1'b0);
        post("n1_ff", d0);

        // Full-length frame with random payload
        d0 = done_cnt;
        d  = {$urandom, $urandom, $urandom, $urandom};
        launch(8'd3, 4'd15, d);
        build_exp(4'd15, d);
        capture("n15_b3", 3, 1'b0);
        post("n15_b3", d0);

        // Start and frame inputs churned throughout; next frame only after done
        d0 = done_cnt;
        d  = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        launch(8'd2, 4'd6, d);
        build_exp(4'd6, d);
        capture("noisy", 2, 1'b1);
        baudrate  = 8'd2;
        size      = 4'd3;
        framedata = d2;
        start     = 1'b1;
        @(negedge clk);
        check("noisy gap_busy", {31'd0, busy}, 32'd0);
        check("noisy gap_tx", {31'd0, TX}, 32'd0);
        check("noisy done_pulses", 32'(done_cnt), 32'(d0 + 1));
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b0;
        build_exp(4'd3, d2);
        capture("after_noisy", 2, 1'b0);
        post("after_noisy", d0);

        // Reset in the middle of the data field
        d0 = done_cnt;
        d  = {$urandom, $urandom, $urandom, $urandom};
        launch(8'd2, 4'd4, d);
        repeat (20) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort tx", {31'd0, TX}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        repeat (80) @(negedge clk);
        check("abort no_done", 32'(done_cnt), 32'(d0));
        check("abort stays_idle", {31'd0, busy}, 32'd0);

        d0 = done_cnt;
        d2 = {$urandom, $urandom, $urandom, $urandom};
        launch(8'd1, 4'd2, d2);
        build_exp(4'd2, d2);
        capture("post_abort", 1, 1'b0);
        post("post_abort", d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
